// File: rtl/adder_share_pkg.sv
// Shared types, widths and the operand interleave helper for the shared-adder arbiter.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int ADDER_WIDTH = 12;
  localparam int PERF_CNT_W  = 16;

  // The attached adder expects bit pairs {b[k], a[k]} at positions 2k+1 / 2k.
  function automatic logic [2*ADDER_WIDTH-1:0] interleave(
    input logic [ADDER_WIDTH-1:0] a,
    input logic [ADDER_WIDTH-1:0] b
  );
    logic [2*ADDER_WIDTH-1:0] bus;
    bus = '0;
    for (int k = 0; k < ADDER_WIDTH; k++) begin
      bus[2*k]   = a[k];
      bus[2*k+1] = b[k];
    end
    return bus;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] cand [NUM_REQ];
  logic            found;

  // Candidate index for each search offset; explicit compare keeps odd NUM_REQ correct.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [ID_W:0] sum;
    assign sum = {1'b0, ptr} + (ID_W+1)'(gi);
    assign cand[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                  : sum[ID_W-1:0];
  end

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (enable && !found && req[cand[k]]) begin
        found          = 1'b1;
        gnt[cand[k]]   = 1'b1;
        gnt_id         = cand[k];
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external adder between NUM_REQ requesters (grant -> exec -> response).
// Optional performance counters are enabled with ADDER_SHARE_PERF_CNT_EN.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = ADDER_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ADDER_SHARE_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0]    op_count,
  output logic [PERF_CNT_W-1:0]    stall_count,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [2*WIDTH-1:0]       add_in,
  input  logic [WIDTH:0]           add_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum
);

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_id_q, rsp_id_q, arb_id;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH:0]  rsp_sum_q;
  logic            rsp_valid_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic            rsp_fire, stall_cycle;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .enable ((state_q == IDLE) && !rst),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  assign req_ready   = arb_gnt;
  assign rsp_fire    = (state_q == RESP) && rsp_valid_q && rsp_ready;
  assign stall_cycle = (state_q == RESP) && !rsp_ready;
  assign rr_ptr_d    = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;

  // Operand registers feed the adder for the whole EXEC cycle.
  assign add_in    = interleave(op_a_q, op_b_q);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            op_a_q   <= req_a[arb_id*WIDTH +: WIDTH];
            op_b_q   <= req_b[arb_id*WIDTH +: WIDTH];
            gnt_id_q <= arb_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= add_out;
          rsp_id_q    <= gnt_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADDER_SHARE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] op_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (rsp_fire && (op_count_q != '1))
        op_count_q <= op_count_q + 1'b1;
      if (stall_cycle && (stall_count_q != '1))
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`else
  // Without counters the handshake strobes have no further consumer.
  logic unused_perf;
  assign unused_perf = rsp_fire ^ stall_cycle;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural adder attached to add_in/add_out.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a, req_b;
  logic [2*W-1:0]  add_in;
  logic [W:0]      add_out;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [W:0]      rsp_sum;
`ifdef ADDER_SHARE_PERF_CNT_EN
  logic [15:0]     op_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ADDER_SHARE_PERF_CNT_EN
    .op_count    (op_count),
    .stall_count (stall_count),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .add_in      (add_in),
    .add_out     (add_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum)
  );

  // Behavioural model of the external adder: de-interleave then add.
  logic [W-1:0] mdl_a, mdl_b;
  always_comb begin
    mdl_a = '0;
    mdl_b = '0;
    for (int k = 0; k < W; k++) begin
      mdl_a[k] = add_in[2*k];
      mdl_b[k] = add_in[2*k+1];
    end
  end
  assign add_out = {1'b0, mdl_a} + {1'b0, mdl_b};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Entered just after a posedge with the FSM in IDLE and requests set up.
  task automatic grant_cycle(input logic [N-1:0] exp_gnt, input logic [W:0] exp_sum,
                             input logic [1:0] exp_id, input int stalls);
    rsp_ready = (stalls == 0);
    @(negedge clk);
    check_eq("grant", 32'(req_ready), 32'(exp_gnt));
    step();
    @(negedge clk);
    check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("exec_req_ready", 32'(req_ready), 32'd0);
    step();
    for (int s = 0; s < stalls; s++) begin
      @(negedge clk);
      check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rsp_sum", 32'(rsp_sum), 32'(exp_sum));
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
    check_eq("rsp_id", 32'(rsp_id), 32'(exp_id));
    $display("op gnt=%b id=%0d sum=0x%0h stalls=%0d", exp_gnt, rsp_id, rsp_sum, stalls);
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    req_a = '0;
    req_b = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_add_in", 32'(add_in), 32'd0);
    step();

    // Single requester with carry-out: 0xFFF + 0x001
    set_op(0, 12'hFFF, 12'h001);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_add_in_lsb", 32'(add_in[1:0]), 32'h3);
    check_eq("t1_add_in", 32'(add_in), 32'h555557);
    check_eq("t1_exec_valid", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t1_rsp_sum", 32'(rsp_sum), 32'h1000);
    check_eq("t1_rsp_id", 32'(rsp_id), 32'd0);
    $display("op gnt=0001 id=%0d sum=0x%0h stalls=0", rsp_id, rsp_sum);
    step();
    @(negedge clk);
    check_eq("t1_idle_valid", 32'(rsp_valid), 32'd0);
    step();

    // All requesters continuously valid: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i), 12'h100);
    req_valid = 4'b1111;
    grant_cycle(4'b0001, 13'h100, 2'd0, 0);
    grant_cycle(4'b0010, 13'h101, 2'd1, 0);
    grant_cycle(4'b0100, 13'h102, 2'd2, 0);
    grant_cycle(4'b1000, 13'h103, 2'd3, 0);
    grant_cycle(4'b0001, 13'h100, 2'd0, 0);
    req_valid = '0;

    // Backpressure: response held for 5 cycles
    do_reset();
    set_op(0, 12'h800, 12'h800);
    req_valid = 4'b0001;
    grant_cycle(4'b0001, 13'h1000, 2'd0, 5);
    req_valid = '0;
    @(negedge clk);
    check_eq("t3_idle_ready", 32'(req_ready), 32'd0);
    check_eq("t3_idle_valid", 32'(rsp_valid), 32'd0);
    step();

    // Pointer at 2 after grants to 0 and 1; then wrap past an idle requester 3
    do_reset();
    set_op(0, 12'h001, 12'h002);
    set_op(1, 12'h010, 12'h020);
    set_op(2, 12'h555, 12'hAAA);
    req_valid = 4'b0011;
    grant_cycle(4'b0001, 13'h003, 2'd0, 0);
    grant_cycle(4'b0010, 13'h030, 2'd1, 0);
    req_valid = 4'b0100;
    grant_cycle(4'b0100, 13'h0FFF, 2'd2, 0);
    req_valid = 4'b0011;
    grant_cycle(4'b0001, 13'h003, 2'd0, 0);
    req_valid = '0;

    // Reset during EXEC drops the operation and restores priority to requester 0
    do_reset();
    set_op(1, 12'h001, 12'h002);
    req_valid = 4'b0010;
    @(negedge clk);
    check_eq("t5_grant", 32'(req_ready), 32'h2);
    step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("t5_add_in", 32'(add_in), 32'd0);
    check_eq("t5_req_ready", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    check_eq("t5_rsp_valid2", 32'(rsp_valid), 32'd0);
    step();
    set_op(0, 12'h010, 12'h020);
    set_op(3, 12'h030, 12'h040);
    req_valid = 4'b1001;
    grant_cycle(4'b0001, 13'h030, 2'd0, 0);
    req_valid = 4'b1000;
    grant_cycle(4'b1000, 13'h070, 2'd3, 0);
    req_valid = '0;

`ifdef ADDER_SHARE_PERF_CNT_EN
    do_reset();
    @(negedge clk);
    check_eq("perf_rst_ops", 32'(op_count), 32'd0);
    check_eq("perf_rst_stalls", 32'(stall_count), 32'd0);
    step();
    set_op(0, 12'h001, 12'h001);
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) grant_cycle(4'b0001, 13'h002, 2'd0, 2);
    req_valid = '0;
    @(negedge clk);
    check_eq("perf_ops", 32'(op_count), 32'd3);
    check_eq("perf_stalls", 32'(stall_count), 32'd6);
    step();
    force dut.op_count_q = 16'hFFFF;
    step();
    release dut.op_count_q;
    req_valid = 4'b0001;
    grant_cycle(4'b0001, 13'h002, 2'd0, 0);
    req_valid = '0;
    @(negedge clk);
    check_eq("perf_ops_sat", 32'(op_count), 32'hFFFF);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
